// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared definitions for the IFU/LSU data-memory arbiter: state encoding,
// owner IDs and default bus widths.
package ysyx_22050612_mem_pkg;

    localparam int unsigned DEF_ADDR_W     = 64;
    localparam int unsigned DEF_DATA_W     = 64;
    localparam int unsigned DEF_MASK_W     = DEF_DATA_W / 8;
    localparam int unsigned DEF_MAX_STREAK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Reads never carry byte enables downstream.
    function automatic logic [DEF_MASK_W-1:0] eff_mask(input logic wen,
                                                       input logic [DEF_MASK_W-1:0] mask);
        return wen ? mask : '0;
    endfunction

endpackage

// File: rtl/ysyx_22050612_prio_streak.sv
// Two-input picker: LSU wins by default, IFU is forced through after
// MAX_STREAK consecutive LSU grants taken while IFU was waiting.
module ysyx_22050612_prio_streak
    import ysyx_22050612_mem_pkg::*;
#(
    parameter int unsigned MAX_STREAK = DEF_MAX_STREAK,
    localparam int unsigned CNT_W     = $clog2(MAX_STREAK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid_i,
    input  logic             ls_valid_i,
    input  logic             take_i,
    output logic [1:0]       grant_c_o,
    output logic [CNT_W-1:0] streak_o
);

    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;
    logic             force_if;

    assign force_if = if_valid_i && (streak_q == CNT_W'(MAX_STREAK));
    assign streak_o = streak_q;

    always_comb begin
        grant_c_o = '0;
        if (ls_valid_i && !force_if) begin
            grant_c_o[OWN_LS] = 1'b1;
        end else if (if_valid_i) begin
            grant_c_o[OWN_IF] = 1'b1;
        end
    end

    // Streak only moves when the grant is actually consumed.
    always_comb begin
        streak_d = streak_q;
        if (take_i && grant_c_o[OWN_LS] && if_valid_i) begin
            if (streak_q != CNT_W'(MAX_STREAK)) begin
                streak_d = streak_q + CNT_W'(1);
            end
        end else if (take_i && (|grant_c_o)) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/ysyx_22050612_mem_arb.sv
// Shares the single data-memory port between IFU fetches and LSU loads/stores:
// one transaction in flight, response routed back to its owner.
module ysyx_22050612_mem_arb
    import ysyx_22050612_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned MASK_W     = DATA_W / 8,
    parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_rdata,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_wen,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    input  logic [MASK_W-1:0] ls_req_wmask,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_resp_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,

    output logic              arb_err
);

    localparam int unsigned CNT_W = $clog2(MAX_STREAK + 1);

    arb_state_e        state_q;
    logic              owner_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              arb_err_q;

    logic [1:0]        grant_c;
    logic [CNT_W-1:0]  streak;
    logic              idle_c;
    logic              resp_c;

    // Ready is masked during reset so every output reads 0 while rst_n is low.
    assign idle_c = rst_n && (state_q == IDLE);
    assign resp_c = (state_q == WAIT) && mem_resp_valid;

    ysyx_22050612_prio_streak #(
        .MAX_STREAK (MAX_STREAK)
    ) u_prio (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid_i (if_req_valid),
        .ls_valid_i (ls_req_valid),
        .take_i     (idle_c),
        .grant_c_o  (grant_c),
        .streak_o   (streak)
    );

    assign if_req_ready = idle_c && grant_c[OWN_IF];
    assign ls_req_ready = idle_c && grant_c[OWN_LS];

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_wen   = wen_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign if_resp_valid = resp_c && (owner_q == OWN_IF);
    assign ls_resp_valid = resp_c && (owner_q == OWN_LS);
    assign if_resp_rdata = if_resp_valid ? mem_resp_rdata : '0;
    assign ls_resp_rdata = (ls_resp_valid && !wen_q) ? mem_resp_rdata : '0;

    assign arb_err = arb_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            arb_err_q <= 1'b0;
        end else begin
            if (mem_resp_valid && (state_q != WAIT)) begin
                arb_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant_c[OWN_LS]) begin
                        owner_q <= OWN_LS;
                        wen_q   <= ls_req_wen;
                        addr_q  <= ls_req_addr;
                        wdata_q <= ls_req_wdata;
                        wmask_q <= ls_req_wen ? ls_req_wmask : '0;
                        state_q <= ISSUE;
                    end else if (grant_c[OWN_IF]) begin
                        owner_q <= OWN_IF;
                        wen_q   <= 1'b0;
                        addr_q  <= if_req_addr;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic unused_streak;
    assign unused_streak = ^streak;

endmodule

// File: tb/tb_ysyx_22050612_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter: one step per cycle, inputs
// driven after the falling edge and outputs checked 1 time unit later.
module tb_ysyx_22050612_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_resp_valid;
    logic [63:0] if_resp_rdata;
    logic        ls_req_valid, ls_req_ready, ls_req_wen;
    logic [63:0] ls_req_addr, ls_req_wdata;
    logic [7:0]  ls_req_wmask;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        arb_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22050612_mem_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_addr    (if_req_addr),
        .if_resp_valid  (if_resp_valid),
        .if_resp_rdata  (if_resp_rdata),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_req_wen     (ls_req_wen),
        .ls_req_addr    (ls_req_addr),
        .ls_req_wdata   (ls_req_wdata),
        .ls_req_wmask   (ls_req_wmask),
        .ls_resp_valid  (ls_resp_valid),
        .ls_resp_rdata  (ls_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .arb_err        (arb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        if_req_valid   = 1'b1;
        if_req_addr    = 64'h0;
        ls_req_valid   = 1'b1;
        ls_req_wen     = 1'b0;
        ls_req_addr    = 64'h0;
        ls_req_wdata   = 64'h0;
        ls_req_wmask   = 8'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'h0;

        // Reset: every output low even with requests pending.
        @(negedge clk); #1;
        chk("rst_if_ready", 64'(if_req_ready), 64'd0);
        chk("rst_ls_ready", 64'(ls_req_ready), 64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_arb_err", 64'(arb_err), 64'd0);
        chk("rst_mem_addr", mem_req_addr, 64'd0);

        // IFU only.
        @(negedge clk);
        rst_n = 1'b1; ls_req_valid = 1'b0;
        if_req_addr = 64'h8000_0000; mem_req_ready = 1'b1; #1;
        chk("if_only_ready", 64'(if_req_ready), 64'd1);
        chk("if_only_ls_ready", 64'(ls_req_ready), 64'd0);
        chk("if_only_idle_nomem", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        if_req_valid = 1'b0; #1;
        chk("if_only_ready_drop", 64'(if_req_ready), 64'd0);
        chk("if_only_mem_valid", 64'(mem_req_valid), 64'd1);
        chk("if_only_mem_addr", mem_req_addr, 64'h8000_0000);
        chk("if_only_mem_wen", 64'(mem_req_wen), 64'd0);
        chk("if_only_mem_wmask", 64'(mem_req_wmask), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h13; #1;
        chk("if_only_wait_nomem", 64'(mem_req_valid), 64'd0);
        chk("if_only_resp_valid", 64'(if_resp_valid), 64'd1);
        chk("if_only_resp_rdata", if_resp_rdata, 64'h13);
        chk("if_only_ls_resp", 64'(ls_resp_valid), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0; #1;
        chk("if_only_resp_pulse", 64'(if_resp_valid), 64'd0);
        chk("if_only_rdata_zero", if_resp_rdata, 64'd0);
        chk("if_only_no_err", 64'(arb_err), 64'd0);

        // Simultaneous: LSU write first, IFU in the next IDLE.
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
        ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_req_addr = 64'h8000_1004;
        ls_req_wdata = 64'hDEAD_BEEF_0000_0000; ls_req_wmask = 8'hF0; #1;
        chk("sim_ls_ready", 64'(ls_req_ready), 64'd1);
        chk("sim_if_ready", 64'(if_req_ready), 64'd0);
        @(negedge clk);
        ls_req_valid = 1'b0; #1;
        chk("sim_mem_wen", 64'(mem_req_wen), 64'd1);
        chk("sim_mem_addr", mem_req_addr, 64'h8000_1004);
        chk("sim_mem_wdata", mem_req_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("sim_mem_wmask", 64'(mem_req_wmask), 64'hF0);
        chk("sim_if_ready_issue", 64'(if_req_ready), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_0000_1234_5678; #1;
        chk("sim_ls_resp", 64'(ls_resp_valid), 64'd1);
        chk("sim_ls_rdata_wr", ls_resp_rdata, 64'd0);
        chk("sim_if_resp", 64'(if_resp_valid), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0; #1;
        chk("sim_if_granted", 64'(if_req_ready), 64'd1);
        @(negedge clk);
        if_req_valid = 1'b0; #1;
        chk("sim_if_addr", mem_req_addr, 64'h8000_0004);
        chk("sim_if_wen", 64'(mem_req_wen), 64'd0);
        chk("sim_if_wmask", 64'(mem_req_wmask), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234; #1;
        chk("sim_if_resp_data", if_resp_rdata, 64'h1234);

        // Starvation: four LSU grants, IFU forced on the fifth.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0; if_req_valid = 1'b1; ls_req_valid = 1'b1;
            ls_req_wen = 1'b0; ls_req_addr = 64'h8000_3000 + 64'(k * 8); #1;
            chk($sformatf("starve_ls_ready_%0d", k), 64'(ls_req_ready), (k < 4) ? 64'd1 : 64'd0);
            chk($sformatf("starve_if_ready_%0d", k), 64'(if_req_ready), (k < 4) ? 64'd0 : 64'd1);
            @(negedge clk);
            #1;
            @(negedge clk);
            mem_resp_valid = 1'b1; mem_resp_rdata = 64'h100 + 64'(k); #1;
            chk($sformatf("starve_ls_resp_%0d", k), 64'(ls_resp_valid), (k < 4) ? 64'd1 : 64'd0);
            chk($sformatf("starve_if_resp_%0d", k), 64'(if_resp_valid), (k < 4) ? 64'd0 : 64'd1);
        end
        chk("starve_streak_clear", 64'(dut.u_prio.streak_q), 64'd0);

        // Backpressure: LSU read held in ISSUE for 5 stalled cycles.
        @(negedge clk);
        mem_resp_valid = 1'b0; if_req_valid = 1'b1; ls_req_valid = 1'b1;
        ls_req_wen = 1'b0; ls_req_addr = 64'h8000_2000; ls_req_wmask = 8'hFF;
        mem_req_ready = 1'b0; #1;
        chk("bp_ls_ready", 64'(ls_req_ready), 64'd1);
        @(negedge clk);
        ls_req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            mem_req_ready = (i == 5); #1;
            chk($sformatf("bp_valid_%0d", i), 64'(mem_req_valid), 64'd1);
            chk($sformatf("bp_addr_%0d", i), mem_req_addr, 64'h8000_2000);
            chk($sformatf("bp_wmask_%0d", i), 64'(mem_req_wmask), 64'd0);
            chk($sformatf("bp_if_ready_%0d", i), 64'(if_req_ready), 64'd0);
        end
        @(negedge clk);
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hAB; #1;
        chk("bp_ls_resp_data", ls_resp_rdata, 64'hAB);
        chk("bp_if_ready_wait", 64'(if_req_ready), 64'd0);

        // Reset mid-WAIT, then a stale response.
        @(negedge clk);
        mem_resp_valid = 1'b0; #1;
        chk("rw_if_grant", 64'(if_req_ready), 64'd1);
        @(negedge clk);
        if_req_valid = 1'b0; #1;
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("rw_rst_resp", 64'(if_resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h55; #1;
        chk("rw_stale_if_resp", 64'(if_resp_valid), 64'd0);
        chk("rw_stale_ls_resp", 64'(ls_resp_valid), 64'd0);
        chk("rw_err_not_yet", 64'(arb_err), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0; #1;
        chk("rw_err_set", 64'(arb_err), 64'd1);
        @(negedge clk); #1;
        chk("rw_err_sticky", 64'(arb_err), 64'd1);

        // Spurious response in IDLE.
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("sp_err_cleared", 64'(arb_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_resp_valid = 1'b1; #1;
        chk("sp_err_before_edge", 64'(arb_err), 64'd0);
        chk("sp_no_mem_req", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0; if_req_valid = 1'b1; #1;
        chk("sp_err_set", 64'(arb_err), 64'd1);
        chk("sp_still_idle", 64'(if_req_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
